slow_clk_monitor: RTL

Receive-side companion to the slow-clock dividers. Samples a divided clock (e.g. the 20 kHz tick-clock, nominally 2500 CLOCK cycles per half period) back in the 100 MHz CLOCK domain, synchronizes it and emits single-cycle edge ticks. It measures every half period and declares LOCKED or FAULT, so downstream logic (display refresh, game tick) can gate on a verified slow clock.

---
 rtl/slow_clk_pkg.sv | 21 ++
 rtl/slow_clk_monitor_if.sv | 45 ++++
 rtl/sync_edge_det.sv | 41 ++++
 rtl/slow_clk_monitor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/slow_clk_pkg.sv
// ----------------------------------------------------------------------------
// slow_clk_pkg
// Shared definitions for the slow-clock dividers and their receive-side monitor.
//   - mon_state_e : slow_clk_monitor FSM states
//   - SLOW_HALF_PERIOD_20K / SLOW_TOL / SLOW_LOCK_COUNT : default monitor settings
//     for the 20 kHz tick clock seen from the 100 MHz CLOCK domain.
// ----------------------------------------------------------------------------
package slow_clk_pkg;

    localparam int unsigned SLOW_HALF_PERIOD_20K = 2500;
    localparam int unsigned SLOW_TOL             = 16;
    localparam int unsigned SLOW_LOCK_COUNT      = 4;

    typedef enum logic [1:0] {
        StIdle,
        StAcquire,
        StLocked,
        StFault
    } mon_state_e;

endpackage

// File: rtl/slow_clk_monitor_if.sv
// ----------------------------------------------------------------------------
// slow_clk_monitor_if
// Bundles the slow-clock monitor's functional signals.
//   SLOW_CLK   : divided clock under test (asynchronous to CLOCK)
//   FAULT_CLR  : level, releases the monitor from FAULT
//   RISE_TICK  : one-cycle pulse per synchronized rising edge
//   FALL_TICK  : one-cycle pulse per synchronized falling edge
//   HALF_LEN   : last measured half period in CLOCK cycles
//   LOCKED     : slow clock verified in tolerance
//   FAULT      : sticky fault indication
// Modports: master drives SLOW_CLK/FAULT_CLR, slave is the monitor.
// ----------------------------------------------------------------------------
interface slow_clk_monitor_if #(
    parameter int unsigned CNT_W = 13
) ();

    logic             SLOW_CLK;
    logic             FAULT_CLR;
    logic             RISE_TICK;
    logic             FALL_TICK;
    logic [CNT_W-1:0] HALF_LEN;
    logic             LOCKED;
    logic             FAULT;

    modport master (
        output SLOW_CLK,
        output FAULT_CLR,
        input  RISE_TICK,
        input  FALL_TICK,
        input  HALF_LEN,
        input  LOCKED,
        input  FAULT
    );

    modport slave (
        input  SLOW_CLK,
        input  FAULT_CLR,
        output RISE_TICK,
        output FALL_TICK,
        output HALF_LEN,
        output LOCKED,
        output FAULT
    );

endinterface

// File: rtl/sync_edge_det.sv
// ----------------------------------------------------------------------------
// sync_edge_det
// Three-flop synchronizer with edge decode for an asynchronous level input.
//   CLOCK    : sampling clock
//   RESET_N  : asynchronous active-low reset, all flops clear to 0
//   ASYNC_IN : asynchronous input level
//   LEVEL    : synchronized level (second flop)
//   RISE     : combinational, high for one cycle after a synchronized 0->1
//   FALL     : combinational, high for one cycle after a synchronized 1->0
// ----------------------------------------------------------------------------
module sync_edge_det (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic ASYNC_IN,
    output logic LEVEL,
    output logic RISE,
    output logic FALL
);

    // s1/s2 form the metastability filter, s3 is the one-cycle history for edges.
    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= ASYNC_IN;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign LEVEL = s2_q;
    assign RISE  = s2_q & ~s3_q;
    assign FALL  = ~s2_q & s3_q;

endmodule

// File: rtl/slow_clk_monitor.sv
// ----------------------------------------------------------------------------
// slow_clk_monitor
// Synchronizes a divided clock into the CLOCK domain, emits edge ticks,
// measures each half period and tracks IDLE -> ACQUIRE -> LOCKED / FAULT.
//   CLOCK    : system clock
//   RESET_N  : asynchronous active-low reset
//   bus      : slow_clk_monitor_if.slave (SLOW_CLK, FAULT_CLR in;
//              RISE_TICK, FALL_TICK, HALF_LEN, LOCKED, FAULT out)
// Parameters: HALF_PERIOD (nominal half period), TOL (inclusive +/- window),
//   LOCK_COUNT (consecutive good halves to lock), CNT_W (counter width,
//   2**CNT_W - 1 must be >= 2*HALF_PERIOD; must match the interface's CNT_W).
// Build option: define SLOW_CLK_MON_TIMEOUT_EN to enable the stuck-clock
//   watchdog (no edge while cnt >= 2*HALF_PERIOD forces FAULT).
// All outputs are registered; they change two posedges after the posedge that
// first samples a new SLOW_CLK level.
// ----------------------------------------------------------------------------
module slow_clk_monitor
    import slow_clk_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = SLOW_HALF_PERIOD_20K,
    parameter int unsigned TOL         = SLOW_TOL,
    parameter int unsigned LOCK_COUNT  = SLOW_LOCK_COUNT,
    parameter int unsigned CNT_W       = 13
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    slow_clk_monitor_if.slave  bus
);

    localparam int unsigned GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam int unsigned LO_INT = (HALF_PERIOD > TOL) ? (HALF_PERIOD - TOL) : 0;

    // Window bounds are one bit wider than cnt so HALF_PERIOD+TOL never wraps.
    localparam logic [CNT_W:0] LO_BOUND = (CNT_W+1)'(LO_INT);
    localparam logic [CNT_W:0] HI_BOUND = (CNT_W+1)'(HALF_PERIOD + TOL);

    logic slow_level;
    logic edge_rise;
    logic edge_fall;
    logic edge_any;

    sync_edge_det u_sync (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .ASYNC_IN (bus.SLOW_CLK),
        .LEVEL    (slow_level),
        .RISE     (edge_rise),
        .FALL     (edge_fall)
    );

    // The synchronized level itself is not needed; edges carry all information.
    logic unused_level;
    assign unused_level = slow_level;

    assign edge_any = edge_rise | edge_fall;

    mon_state_e        state_q, state_d;
    logic [GW-1:0]     good_q, good_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  half_len_q;
    logic              rise_q;
    logic              fall_q;
    logic              locked_q;
    logic              fault_q;

    logic [CNT_W:0]    cnt_ext;
    logic              meas_good;
    logic              clear_fire;
    logic              timeout_hit;

    assign cnt_ext    = {1'b0, cnt_q};
    assign meas_good  = (cnt_ext >= LO_BOUND) && (cnt_ext <= HI_BOUND);
    assign clear_fire = (state_q == StFault) && bus.FAULT_CLR;

`ifdef SLOW_CLK_MON_TIMEOUT_EN
    localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(2 * HALF_PERIOD);
    // An edge in the same cycle takes precedence over the watchdog.
    assign timeout_hit = !edge_any && (cnt_ext >= TIMEOUT_LIM);
`else
    assign timeout_hit = 1'b0;
`endif

    // Half-period counter: restarts at 1 on each edge, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_fire) begin
            cnt_d = '0;
        end else if (edge_any) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            StIdle: begin
                // First edge only establishes a reference point; no measurement.
                if (edge_any) begin
                    state_d = StAcquire;
                    good_d  = '0;
                end else if (timeout_hit) begin
                    state_d = StFault;
                end
            end
            StAcquire: begin
                if (edge_any) begin
                    if (meas_good) begin
                        good_d = good_q + GW'(1);
                        if (good_q == GW'(LOCK_COUNT - 1)) begin
                            state_d = StLocked;
                        end
                    end else begin
                        good_d = '0;
                    end
                end else if (timeout_hit) begin
                    state_d = StFault;
                end
            end
            StLocked: begin
                if (edge_any) begin
                    if (!meas_good) begin
                        state_d = StFault;
                    end
                end else if (timeout_hit) begin
                    state_d = StFault;
                end
            end
            StFault: begin
                // Clear wins over a coincident edge; that edge is discarded.
                if (bus.FAULT_CLR) begin
                    state_d = StIdle;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                good_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            good_q     <= '0;
            cnt_q      <= '0;
            half_len_q <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            locked_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            cnt_q    <= cnt_d;
            rise_q   <= edge_rise;
            fall_q   <= edge_fall;
            locked_q <= (state_d == StLocked);
            fault_q  <= (state_d == StFault);
            if (edge_any && (state_q != StIdle)) begin
                half_len_q <= cnt_q;
            end
        end
    end

    assign bus.RISE_TICK = rise_q;
    assign bus.FALL_TICK = fall_q;
    assign bus.HALF_LEN  = half_len_q;
    assign bus.LOCKED    = locked_q;
    assign bus.FAULT     = fault_q;

endmodule
